// File: rtl/mant_normalizer.sv
// Post-add mantissa normaliser: iterative left-shift FSM with carry fix-up,
// zero/denormal/overflow detection and valid/ready handshakes on both sides.
module mant_normalizer #(
   parameter int WORD_SIZE = 24,
   parameter int EXP_WIDTH = 8,
   parameter int CNT_WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WORD_SIZE:0]   mant_in,
   input  logic [EXP_WIDTH-1:0] exp_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WORD_SIZE-1:0] mant_out,
   output logic [EXP_WIDTH-1:0] exp_out,
   output logic [CNT_WIDTH-1:0] shift_cnt,
   output logic                 zero,
   output logic                 denorm,
   output logic                 ovf
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NORM = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [EXP_WIDTH-1:0] EXP_MAX = '1;
   localparam logic [EXP_WIDTH-1:0] EXP_PRE = EXP_MAX - 1'b1;

   state_t               state;
   logic [WORD_SIZE:0]   mant_r;
   logic [EXP_WIDTH-1:0] exp_r;

   // Mutually exclusive NORM decisions, already resolved by priority
   logic is_carry;
   logic is_zero;
   logic is_hid;
   logic is_den;
   logic is_shift;
   logic carry_ovf;

   always_comb begin
      is_carry  = mant_r[WORD_SIZE];
      is_zero   = !is_carry && (mant_r == '0);
      is_hid    = !is_carry && !is_zero && mant_r[WORD_SIZE-1];
      is_den    = !is_carry && !is_zero && !is_hid && (exp_r == '0);
      is_shift  = !is_carry && !is_zero && !is_hid && !is_den;
      carry_ovf = (exp_r >= EXP_PRE);
   end

   assign in_ready = (state == IDLE);
   assign mant_out = mant_r[WORD_SIZE-1:0];
   assign exp_out  = exp_r;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         mant_r    <= '0;
         exp_r     <= '0;
         shift_cnt <= '0;
         zero      <= 1'b0;
         denorm    <= 1'b0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  mant_r    <= mant_in;
                  exp_r     <= exp_in;
                  shift_cnt <= '0;
                  zero      <= 1'b0;
                  denorm    <= 1'b0;
                  ovf       <= 1'b0;
                  out_valid <= 1'b0;
                  state     <= NORM;
               end
            end
            NORM: begin
               unique case (1'b1)
                  is_carry: begin
                     if (carry_ovf) begin
                        mant_r <= '0;
                        exp_r  <= EXP_MAX;
                        ovf    <= 1'b1;
                     end else begin
                        mant_r <= mant_r >> 1;
                        exp_r  <= exp_r + 1'b1;
                     end
                     state <= DONE;
                  end
                  is_zero: begin
                     zero  <= 1'b1;
                     exp_r <= '0;
                     state <= DONE;
                  end
                  is_hid: begin
                     state <= DONE;
                  end
                  is_den: begin
                     denorm <= 1'b1;
                     state  <= DONE;
                  end
                  is_shift: begin
                     mant_r    <= {mant_r[WORD_SIZE-1:0], 1'b0};
                     exp_r     <= exp_r - 1'b1;
                     shift_cnt <= shift_cnt + 1'b1;
                  end
               endcase
            end
            DONE: begin
               // out_valid rises one cycle after entering DONE
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end else begin
                  out_valid <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mant_normalizer.sv
// Bench for mant_normalizer: directed vector table, random operands against a
// behavioural model, and handshake/reset corner sequences.
module tb_mant_normalizer;

   logic        clk;
   logic        rstn;
   logic        in_valid;
   logic        in_ready;
   logic [24:0] mant_in;
   logic [7:0]  exp_in;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] mant_out;
   logic [7:0]  exp_out;
   logic [4:0]  shift_cnt;
   logic        zero;
   logic        denorm;
   logic        ovf;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [24:0] mi;
      logic [7:0]  ei;
      logic [23:0] mo;
      logic [7:0]  eo;
      logic [4:0]  cnt;
      logic        z;
      logic        d;
      logic        o;
      int          lat;
   } vec_t;

   mant_normalizer dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mant_in   (mant_in),
      .exp_in    (exp_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .mant_out  (mant_out),
      .exp_out   (exp_out),
      .shift_cnt (shift_cnt),
      .zero      (zero),
      .denorm    (denorm),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   // Reference: normalisation computed with plain integer arithmetic
   function automatic vec_t model(input logic [24:0] mi, input logic [7:0] ei);
      vec_t r;
      longint m;
      int e;
      int k;
      r.mi = mi;
      r.ei = ei;
      m = longint'(mi);
      e = int'(ei);
      k = 0;
      r.z = 0;
      r.d = 0;
      r.o = 0;
      if (m >= 64'h1000000) begin
         m = m / 2;
         e = e + 1;
         if (e >= 255) begin
            e = 255;
            m = 0;
            r.o = 1;
         end
      end else if (m == 0) begin
         e = 0;
         r.z = 1;
      end else begin
         while (m < 64'h800000 && e > 0) begin
            m = m * 2;
            e = e - 1;
            k = k + 1;
         end
         r.d = (m < 64'h800000);
      end
      r.mo  = m[23:0];
      r.eo  = e[7:0];
      r.cnt = k[4:0];
      r.lat = 2 + k;
      return r;
   endfunction

   task automatic check_op(input string nm, input vec_t v);
      int cyc;
      bit seen;
      chk({nm, ".in_ready_idle"}, in_ready, 1);
      mant_in  = v.mi;
      exp_in   = v.ei;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk({nm, ".in_ready_busy"}, in_ready, 0);
      cyc  = 0;
      seen = 0;
      while (!seen && cyc < 40) begin
         @(posedge clk);
         cyc++;
         #1;
         seen = out_valid;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s.timeout: out_valid never rose in %0d cycles", nm, cyc);
      end else begin
         chk({nm, ".lat"},    cyc,       v.lat);
         chk({nm, ".mant"},   mant_out,  v.mo);
         chk({nm, ".exp"},    exp_out,   v.eo);
         chk({nm, ".cnt"},    shift_cnt, v.cnt);
         chk({nm, ".zero"},   zero,      v.z);
         chk({nm, ".denorm"}, denorm,    v.d);
         chk({nm, ".ovf"},    ovf,       v.o);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({nm, ".released"}, out_valid, 0);
   endtask

   vec_t tbl[6];
   vec_t v;

   initial begin
      tbl[0] = '{25'h0000001,  8'd100, 24'h800000,  8'd77, 5'd23, 0, 0, 0, 25};
      tbl[1] = '{25'h1800000,  8'd10,  24'hC00000,  8'd11, 5'd0,  0, 0, 0, 2};
      tbl[2] = '{25'h1000000,  8'd254, 24'h000000,  8'd255, 5'd0, 0, 0, 1, 2};
      tbl[3] = '{25'h0000000,  8'd50,  24'h000000,  8'd0,  5'd0,  1, 0, 0, 2};
      tbl[4] = '{25'h0000100,  8'd3,   24'h000800,  8'd0,  5'd3,  0, 1, 0, 5};
      tbl[5] = '{25'h0400000,  8'd1,   24'h800000,  8'd0,  5'd1,  0, 0, 0, 3};

      rstn      = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      mant_in   = '0;
      exp_in    = '0;
      #22;
      chk("rst.out_valid", out_valid, 0);
      chk("rst.in_ready",  in_ready,  1);
      chk("rst.mant",      mant_out,  0);
      chk("rst.flags",     {zero, denorm, ovf}, 0);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      foreach (tbl[i]) check_op($sformatf("vec%0d", i), tbl[i]);

      for (int i = 0; i < 60; i++) begin
         logic [24:0] mi;
         logic [7:0]  ei;
         mi = 25'($urandom) >> $urandom_range(0, 25);
         ei = 8'($urandom);
         if (i % 10 == 0) ei = 8'd255;
         check_op($sformatf("rnd%0d", i), model(mi, ei));
      end

      // Hold result with out_ready low, then abort a later op with reset
      v = model(25'h0000001, 8'd100);
      mant_in  = v.mi;
      exp_in   = v.ei;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int i = 0; i < 40 && !out_valid; i++) begin
         @(posedge clk);
         #1;
      end
      chk("hold.valid0", out_valid, 1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("hold.valid",    out_valid, 1);
         chk("hold.in_ready", in_ready,  0);
         chk("hold.mant",     mant_out,  24'h800000);
         chk("hold.exp",      exp_out,   8'd77);
         chk("hold.cnt",      shift_cnt, 5'd23);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      mant_in   = 25'h0000001;
      exp_in    = 8'd100;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("abort.busy", in_ready, 0);
      rstn = 1'b0;
      #1;
      chk("abort.valid",    out_valid, 0);
      chk("abort.cnt",      shift_cnt, 0);
      chk("abort.mant",     mant_out,  0);
      chk("abort.flags",    {zero, denorm, ovf}, 0);
      chk("abort.in_ready", in_ready,  1);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      check_op("post_rst", model(25'h0000100, 8'd3));
      check_op("post_rst2", model(25'h1FFFFFF, 8'd200));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
